// File: rtl/cmp2_max_seq.sv
// Frame sequencer around one shared 2-bit magnitude comparator.
// Streams N unsigned 2-bit samples over a valid/ready handshake and keeps the
// running maximum, the index of its first occurrence and the count of later
// ties. A one-cycle done pulse marks the end of each frame.
module cmp2_max_seq #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic          in_valid,
    input  logic [1:0]    in_data,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [1:0]    max_val,
    output logic [IW-1:0] max_idx,
    output logic [IW-1:0] tie_cnt
);

    // The sample counter has to reach N, so it is one bit wider than IW
    // when N is a power of two.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;
    logic          ge;
    logic          ne;
    logic          gt;
    logic          eq;

    // Tie counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
        return (&v) ? v : v + IW'(1);
    endfunction

    // Shared comparator: new sample against the running maximum.
    assign ge = (in_data >= max_val);
    assign ne = (in_data != max_val);
    assign gt = ge & ne;
    assign eq = ge & ~ne;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; handshake and status flags decode from state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = (N == 1) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result and counter registers; they only move on an accepted sample,
    // so results persist through DONE and IDLE until the next frame loads.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            max_val <= 2'd0;
            max_idx <= '0;
            tie_cnt <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (state == LOAD) begin
                max_val <= in_data;
                max_idx <= '0;
                tie_cnt <= '0;
                cnt     <= CW'(1);
            end else begin
                if (gt) begin
                    max_val <= in_data;
                    max_idx <= cnt[IW-1:0];
                    tie_cnt <= '0;
                end else if (eq) begin
                    tie_cnt <= sat_inc(tie_cnt);
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp2_max_seq.sv
// Bench for cmp2_max_seq: an N=4 instance and an N=1 instance share clock and
// reset. Drivers push expected frame results into queues; monitors pop and
// compare whenever a done pulse appears.
module tb_cmp2_max_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       st4, v4, r4, b4, dn4;
    logic [1:0] d4, mv4, mi4, tc4;

    logic       st1, v1, r1, b1, dn1;
    logic [1:0] d1, mv1;
    logic [0:0] mi1, tc1;

    cmp2_max_seq #(.N(4)) u4 (
        .Clock(clk), .Resetn(rst_n), .start(st4), .in_valid(v4), .in_data(d4),
        .in_ready(r4), .busy(b4), .done(dn4), .max_val(mv4), .max_idx(mi4), .tie_cnt(tc4)
    );

    cmp2_max_seq #(.N(1)) u1 (
        .Clock(clk), .Resetn(rst_n), .start(st1), .in_valid(v1), .in_data(d1),
        .in_ready(r1), .busy(b1), .done(dn1), .max_val(mv1), .max_idx(mi1), .tie_cnt(tc1)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int mv;
        int mi;
        int tc;
        int busy;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame result straight from the definition: maximum of the frame, first
    // position holding it, and how many later positions also hold it.
    function automatic exp_t model(input int s[$], input int iw, input int bl);
        exp_t e;
        int   mx;
        mx = -1;
        foreach (s[i]) if (s[i] > mx) mx = s[i];
        e.mv = mx;
        e.mi = -1;
        e.tc = 0;
        foreach (s[i]) begin
            if (s[i] == mx) begin
                if (e.mi < 0) e.mi = i;
                else          e.tc++;
            end
        end
        if (e.tc > (1 << iw) - 1) e.tc = (1 << iw) - 1;
        e.busy = bl;
        return e;
    endfunction

    // Monitor for the N=4 instance.
    int busy_cnt4 = 0;
    bit prev_acc4 = 0;
    bit prev_dn4  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt4 = 0;
            prev_acc4 = 0;
            prev_dn4  = 0;
        end else begin
            if (b4) busy_cnt4++;
            if (dn4) begin
                chk("n4_done_after_last_accept", 32'(prev_acc4), 1);
                chk("n4_done_one_cycle", 32'(prev_dn4), 0);
                if (q4.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL n4_unexpected_done: got done with no frame pending, expected none");
                end else begin
                    e = q4.pop_front();
                    chk("n4_max_val", 32'(mv4), e.mv);
                    chk("n4_max_idx", 32'(mi4), e.mi);
                    chk("n4_tie_cnt", 32'(tc4), e.tc);
                    chk("n4_busy_len", 32'(busy_cnt4), e.busy);
                end
                busy_cnt4 = 0;
            end
            prev_dn4  = dn4;
            prev_acc4 = v4 & r4;
        end
    end

    // Monitor for the N=1 instance.
    int busy_cnt1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt1 = 0;
        end else begin
            if (b1) busy_cnt1++;
            if (dn1) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL n1_unexpected_done: got done with no frame pending, expected none");
                end else begin
                    e = q1.pop_front();
                    chk("n1_max_val", 32'(mv1), e.mv);
                    chk("n1_max_idx", 32'(mi1), e.mi);
                    chk("n1_tie_cnt", 32'(tc1), e.tc);
                    chk("n1_busy_len", 32'(busy_cnt1), e.busy);
                end
                busy_cnt1 = 0;
            end
        end
    end

    // Run one N=4 frame: start pulse, four samples with optional stalls
    // (random data on the bus, optional start pulses), then wait for done
    // and confirm the results hold in IDLE.
    task automatic frame4(input int s[4], input int stall, input bit mid_start);
        int   qq[$];
        exp_t e;
        foreach (s[i]) qq.push_back(s[i]);
        e = model(qq, 2, 4 + 3 * stall);
        q4.push_back(e);
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("n4_in_ready_when_sending", 32'(r4), 1);
            v4 = 1'b1;
            d4 = 2'(s[i]);
            tick();
            v4 = 1'b0;
            d4 = 2'($urandom_range(0, 3));
            if (i < 3) begin
                for (int k = 0; k < stall; k++) begin
                    if (mid_start) st4 = 1'b1;
                    tick();
                    st4 = 1'b0;
                end
            end
        end
        for (int k = 0; k < 8 && q4.size() != 0; k++) tick();
        chk("n4_frame_completed", 32'(q4.size()), 0);
        tick();
        chk("n4_idle_busy", 32'(b4), 0);
        chk("n4_hold_max_val", 32'(mv4), e.mv);
        chk("n4_hold_max_idx", 32'(mi4), e.mi);
        chk("n4_hold_tie_cnt", 32'(tc4), e.tc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a[4];
        exp_t e1;
        rst_n = 1'b0;
        st4 = 0; v4 = 0; d4 = 0;
        st1 = 0; v1 = 0; d1 = 0;
        #2;
        chk("rst_in_ready", 32'(r4), 0);
        chk("rst_busy", 32'(b4), 0);
        chk("rst_done", 32'(dn4), 0);
        chk("rst_max_val", 32'(mv4), 0);
        chk("rst_max_idx", 32'(mi4), 0);
        chk("rst_tie_cnt", 32'(tc4), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed frames.
        a = '{1, 3, 2, 0}; frame4(a, 0, 0);
        a = '{2, 2, 1, 2}; frame4(a, 0, 0);
        a = '{1, 1, 3, 3}; frame4(a, 0, 0);
        a = '{0, 2, 1, 3}; frame4(a, 3, 1);
        a = '{3, 3, 3, 3}; frame4(a, 0, 0);

        // Reset mid-RUN after two accepts, then a clean frame.
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        v4 = 1'b1; d4 = 2'd1;
        tick();
        d4 = 2'd2;
        tick();
        v4 = 1'b0;
        chk("midrun_busy_before_reset", 32'(b4), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 32'(r4), 0);
        chk("midrun_rst_busy", 32'(b4), 0);
        chk("midrun_rst_done", 32'(dn4), 0);
        chk("midrun_rst_max_val", 32'(mv4), 0);
        chk("midrun_rst_max_idx", 32'(mi4), 0);
        chk("midrun_rst_tie_cnt", 32'(tc4), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrun_idle_after_reset", 32'(b4), 0);
        a = '{3, 0, 3, 1}; frame4(a, 0, 0);

        // N=1: LOAD goes straight to DONE; held start relaunches.
        st1 = 1'b1;
        tick();
        chk("n1_load_ready", 32'(r1), 1);
        e1 = model('{2}, 1, 1);
        q1.push_back(e1);
        v1 = 1'b1; d1 = 2'd2;
        tick();
        v1 = 1'b0;
        chk("n1_done_after_load", 32'(dn1), 1);
        tick();
        chk("n1_idle_busy", 32'(b1), 0);
        chk("n1_hold_max_val", 32'(mv1), 2);
        tick();
        chk("n1_relaunch_busy", 32'(b1), 1);
        chk("n1_relaunch_ready", 32'(r1), 1);
        d1 = 2'($urandom_range(0, 3));
        e1 = model('{int'(d1)}, 1, 1);
        q1.push_back(e1);
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        st1 = 1'b0;
        tick();
        tick();
        chk("n1_frames_completed", 32'(q1.size()), 0);

        // Randomised N=4 frames.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 4; i++) a[i] = int'($urandom_range(0, 3));
            frame4(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmp2_max_seq.md
Name: cmp2_max_seq

Overview:
- Sequencing controller around a single shared 2-bit magnitude comparator (ge / ne).
- Streams a frame of N unsigned 2-bit samples through the comparator over a valid/ready handshake, one per accepted cycle.
- Tracks the running maximum, the index of its first occurrence, and the tie count.
- Reports frame results with a one-cycle done pulse; the standard consumer of the 2-bit compare datapath in the lab designs.

Parameters:
- N, 8, samples per frame; legal range 1..256.
- IW, $clog2(N) (min 1), width of index and tie-count outputs; derived, not overridden.

Ports:
- Clock  input  1  rising-edge system clock.
- Resetn  input  1  asynchronous active-low reset.
- start  input  1  begins a frame; sampled only in IDLE.
- in_valid  input  1  sample on in_data is valid.
- in_data  input  2  unsigned sample {x1,x0}.
- in_ready  output  1  controller will accept in_data this cycle.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse; results final.
- max_val  output  2  running/final maximum.
- max_idx  output  IW  index (0-based) of first sample equal to max_val.
- tie_cnt  output  IW  count of later samples equal to max_val (saturating at 2^IW-1).

Behaviour:
- Reset (Resetn=0, any time, incl. mid-frame): state=IDLE; in_ready=0, busy=0, done=0, max_val=0, max_idx=0, tie_cnt=0, sample counter cnt=0. Takes effect immediately, no clock needed.
- Accept event: in_valid & in_ready at a rising Clock edge. in_data is ignored when in_ready=0.
- Comparator is combinational: ge = (in_data >= max_val), ne = (in_data != max_val). gt = ge & ne, eq = ge & ~ne.
- FSM states:
  - IDLE: in_ready=0, busy=0. start=1 -> LOAD next cycle.
  - LOAD: in_ready=1, busy=1. On accept, unconditionally: max_val<=in_data, max_idx<=0, tie_cnt<=0, cnt<=1. Next state is DONE if N==1, otherwise RUN. Without an accept, remain in LOAD.
  - RUN: in_ready=1, busy=1. On accept:
    - gt: max_val<=in_data, max_idx<=cnt, tie_cnt<=0.
    - eq: tie_cnt<=tie_cnt+1, saturating.
    - less: hold max_val, max_idx and tie_cnt.
    - cnt<=cnt+1. If cnt==N-1 at the accept, next state is DONE.
  - DONE: done=1 for exactly one cycle, in_ready=0, busy=0. Next state is IDLE unconditionally.
- Ties: first occurrence wins max_idx. A later strictly-greater sample clears tie_cnt.
- Latency: done is asserted in the cycle after the Nth accept; results are registered and valid in that same cycle.
- Results hold after DONE through IDLE until the first accept of the next frame.
- start is ignored in LOAD, RUN and DONE; no queuing. A start held high continuously relaunches one cycle after the DONE->IDLE transition.
- in_valid may stall for any number of cycles without state change; counter and results hold.
- Outputs max_val, max_idx and tie_cnt are registers; in_ready, busy and done decode from state only, with no combinational path from in_valid.

Test Plan:
- Reset mid-RUN (N=4, after 2 accepts, Resetn low for 1 cycle) -> all outputs 0 immediately, state IDLE; a later start runs a full 4-sample frame normally.
- N=4, start then stream 1,3,2,0 back-to-back -> done pulses 1 cycle after the 4th accept; max_val=3, max_idx=1, tie_cnt=0; busy high for exactly 4 cycles.
- N=4, stream 2,2,1,2 -> max_val=2, max_idx=0, tie_cnt=2.
- N=4, stream 1,1,3,3 -> max_val=3, max_idx=2, tie_cnt=1 (the earlier tie is cleared on the gt update).
- N=4, stream 0,2,1,3 with in_valid low for 3 cycles between each sample -> same result as the no-stall case (max_val=3, max_idx=3); no accepts while in_valid=0; start pulsed mid-frame has no effect.
- N=1, start, single sample 2 -> LOAD goes straight to DONE; max_val=2, max_idx=0, tie_cnt=0; start held high relaunches the next frame.
